// File: rtl/seq_mul_add_pkg.sv
// Shared arithmetic definitions: multiplier FSM encodings and the signed/unsigned
// mode constants that the divider family also uses.
package seq_mul_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Width of an iteration counter that must reach width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_mul_add_core.sv
// Unsigned shift-add multiplier datapath: one multiplier bit per cycle, WIDTH steps
// after a start strobe; o_last marks the final step.
module seq_mul_add_core
    import seq_mul_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplr,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;

    // The carry out of the upper-half add shifts straight back into the accumulator.
    assign w_addend  = r_mplr[0] ? {1'b0, r_mcand} : '0;
    assign w_sum     = {1'b0, r_acc} + w_addend;
    assign o_last    = r_busy && (r_cnt == LAST_CNT);
    assign o_product = {r_acc, r_mplr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mplr  <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_acc   <= '0;
            r_mplr  <= i_mplr;
            r_mcand <= i_mcand;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= w_sum[WIDTH:1];
            r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
            r_cnt  <= r_cnt + CW'(1);
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_mul_add.sv
// Iterative multiply-accumulate result = a*b + c (signed or unsigned), exact in
// 2*WIDTH bits; rebuilds a divider's dividend from {quotient, divisor, remainder}.
module seq_mul_add
    import seq_mul_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow
);

    state_t r_state;
    state_t w_state_next;

    logic               r_signed;
    logic               r_neg;
    logic [WIDTH-1:0]   r_c;
    logic [2*WIDTH-1:0] r_result;
    logic               r_overflow;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [2*WIDTH-1:0] w_c_ext;
    logic [2*WIDTH-1:0] w_sum;
    logic               w_ovf;

    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

    // Magnitudes are unsigned, so |-2^(WIDTH-1)| fits without an extra bit.
    assign w_a_neg = (is_signed == MODE_SIGNED) && a[WIDTH-1];
    assign w_b_neg = (is_signed == MODE_SIGNED) && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    seq_mul_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept),
        .i_mcand   (w_a_mag),
        .i_mplr    (w_b_mag),
        .o_last    (w_last),
        .o_product (w_product)
    );

    assign w_prod_signed = r_neg ? -w_product : w_product;
    assign w_c_ext       = (r_signed == MODE_SIGNED) ? {{WIDTH{r_c[WIDTH-1]}}, r_c}
                                                     : {{WIDTH{1'b0}}, r_c};
    assign w_sum         = w_prod_signed + w_c_ext;
    assign w_ovf         = (r_signed == MODE_SIGNED)
                         ? !((&w_sum[2*WIDTH-1:WIDTH-1]) || !(|w_sum[2*WIDTH-1:WIDTH-1]))
                         : (|w_sum[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)                   w_state_next = ST_MUL;
            ST_MUL:  if (w_last)                     w_state_next = ST_FIX;
            ST_FIX:                                  w_state_next = ST_DONE;
            ST_DONE: if (r_out_valid && out_ready)   w_state_next = ST_IDLE;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    // out_valid is registered one cycle into DONE so result is stable when it rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_signed    <= MODE_UNSIGNED;
            r_neg       <= 1'b0;
            r_c         <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_signed <= is_signed;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_c      <= c;
            end
            if (r_state == ST_FIX) begin
                r_result   <= w_sum;
                r_overflow <= w_ovf;
            end
            r_out_valid <= (r_state == ST_DONE) && !(r_out_valid && out_ready);
        end
    end

endmodule

// File: tb/tb_seq_mul_add.sv
// Scoreboard bench for seq_mul_add: expected results are queued at issue and
// compared when out_valid appears, along with latency and handshake behaviour.
module tb_seq_mul_add;

    localparam int W = 8;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           is_signed = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a         = '0;
    logic [W-1:0]   b         = '0;
    logic [W-1:0]   c         = '0;
    logic           in_ready;
    logic           out_valid;
    logic           overflow;
    logic [2*W-1:0] result;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    seq_mul_add #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [7:0] ma, input logic [7:0] mb,
                                   input logic [7:0] mc);
        int   av, bv, cv, full;
        exp_t e;
        if (s) begin
            av = $signed(ma);
            bv = $signed(mb);
            cv = $signed(mc);
        end else begin
            av = ma;
            bv = mb;
            cv = mc;
        end
        full  = av * bv + cv;
        e.res = full[15:0];
        e.ovf = s ? ((full < -128) || (full > 127)) : (full > 255);
        return e;
    endfunction

    task automatic run_op(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ic, input int hold);
        exp_t        e;
        int          n;
        logic [15:0] r0;
        logic        o0;
        sb_q.push_back(model(s, ia, ib, ic));
        is_signed = s;
        a = ia;
        b = ib;
        c = ic;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", 32'(n < 50), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ia;
        b = ~ib;
        c = ~ic;
        is_signed = ~s;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 10);
        if (!out_valid) begin
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("overflow", overflow, e.ovf);
        check("in_ready_done", in_ready, 0);
        r0 = result;
        o0 = overflow;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, r0);
            check("hold_ovf", overflow, o0);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        $display("op s=%0d a=%02h b=%02h c=%02h -> result=%04h ovf=%0d (exp %04h/%0d)",
                 s, ia, ib, ic, r0, o0, e.res, e.ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        run_op(1'b0, 8'd33, 8'd3, 8'd1, 0);
        run_op(1'b0, 8'd25, 8'd10, 8'd5, 0);
        run_op(1'b1, 8'hDF, 8'h03, 8'hFF, 0);
        run_op(1'b1, 8'hDF, 8'hFD, 8'h01, 0);
        run_op(1'b1, 8'h21, 8'hFD, 8'hFF, 0);
        run_op(1'b0, 8'hFF, 8'hFF, 8'h00, 0);
        run_op(1'b1, 8'h80, 8'hFF, 8'h00, 0);
        run_op(1'b1, 8'h80, 8'h01, 8'h00, 0);
        run_op(1'b1, 8'h80, 8'h80, 8'h7F, 0);
        run_op(1'b0, 8'd0, 8'd200, 8'd17, 5);
        run_op(1'b1, 8'd5, 8'd0, 8'hFC, 0);
        for (int i = 0; i < 6; i++) begin
            run_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 2));
        end

        // Reset in the 4th MUL cycle discards the operation.
        sb_q.push_back(model(1'b0, 8'hAB, 8'hCD, 8'h11));
        is_signed = 1'b0;
        a = 8'hAB;
        b = 8'hCD;
        c = 8'h11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        check("midrst_overflow", overflow, 0);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_stale", seen, 0);
        $display("reset mid-operation: stale result suppressed=%0d", !seen);
        run_op(1'b0, 8'd7, 8'd6, 8'd0, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
